jk_count_ctrl: RTL and testbench
================================

// Module: jk_count_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH JK flip-flops that forms a mod-MODULUS up/down counter.
//  Each cycle it computes the J/K excitation per bit: hold, set, clear or toggle.
//  It provides run/pause/stop control, parallel load and a terminal-count pulse.
//  It sits between the lab control logic and the JK storage cells; J/K are exported for observation.
// PARAMETERS
//  WIDTH    4   counter/bank width in bits
//  MODULUS  10  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  Clk      in   1      single clock, rising edge
//  Resetn   in   1      asynchronous, active-high reset (1 = reset asserted)
//  Start    in   1      level, sampled each edge: IDLE/PAUSE -> RUN
//  Stop     in   1      level, sampled each edge: RUN -> PAUSE; PAUSE -> IDLE (clears Q)
//  Up       in   1      1 = count up, 0 = count down; sampled every RUN cycle
//  LoadEn   in   1      load LoadVal; honoured only in IDLE or PAUSE
//  LoadVal  in   WIDTH  parallel load value
//  Q        out  WIDTH  counter value (outputs of JK bank)
//  J        out  WIDTH  J excitation applied this cycle
//  K        out  WIDTH  K excitation applied this cycle
//  Busy     out  1      1 while state == RUN
//  Tc       out  1      registered one-cycle pulse after a wrap edge
// BEHAVIOUR
//  - Reset (Resetn=1, async, no edge needed): Q=0, state=IDLE, Busy=0, Tc=0; J=0, K=0 while held.
//  - Encodings: HOLD J=0/K=0; CLR J=0/K=1; SET J=1/K=0; TOG J=1/K=1. J/K are combinational from state, Q and inputs.
//  - Per-bit excitation derives from target next value N: bits with N!=Q TOG; else HOLD.
//    Load and clear drive SET/CLR explicitly (bit=1 SET, bit=0 CLR), never TOG.
//  - FSM states: IDLE, RUN, PAUSE.
//    - IDLE:  Stop -> stay IDLE; else Start -> RUN; else LoadEn -> load, stay IDLE.
//    - RUN:   Stop -> PAUSE with Q held; else count one step.
//    - PAUSE: Stop -> IDLE with Q cleared (all CLR); else Start -> RUN; else LoadEn -> load.
//  - Simultaneous Start and Stop: Stop wins in every state.
//  - Load priority: lower than Start. LoadEn is ignored in RUN.
//  - Load clamp: LoadVal >= MODULUS loads MODULUS-1.
//  - Latency: Start sampled at edge n puts the FSM in RUN after n; the first count occurs at edge n+1.
//  - Count wrap (up): Q=MODULUS-1 -> 0. Count wrap (down): Q=0 -> MODULUS-1.
//    Tc=1 for exactly the cycle after a wrap edge. No Tc on load, clear or pause.
//  - Direction change takes effect at the next edge. No Tc unless a wrap actually occurs.
//  - Width rules: next-value arithmetic is WIDTH+1 bits wide to avoid overflow at MODULUS=2**WIDTH.
//  - HOLD outside counting: IDLE and PAUSE with no command drive all bits HOLD.
// STRUCTURE
//  - Package jk_pkg holds:
//    - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
//    - excitation codes JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11
//  - Sub-module jk_cell: one JK flop with ports Clk, Resetn (async active-high), J, K, Q.
//    It is instantiated WIDTH times via generate.
//  - The controller contains the FSM, next-value and excitation logic, and the Tc register only.
// TESTING (WIDTH=4, MODULUS=10, Clk period 40ns)
//  1. Count up with wrap:
//     - Stimulus: reset, then Start=1 for one cycle with Up=1.
//     - Response: Q goes 0,1,...,9,0 on successive edges; Tc=1 only in the cycle after 9->0; Busy=1 throughout.
//  2. Count down with wrap:
//     - Stimulus: Up=0 in RUN starting from Q=0.
//     - Response: Q=9, Tc pulses; on the 3->2 step, J=K=0001.
//  3. Load and clamp:
//     - Stimulus: in IDLE, LoadEn with LoadVal=7, then LoadEn with LoadVal=12.
//     - Response: LoadVal=7 gives J=0111, K=1000, Q=7 next edge; LoadVal=12 gives Q=9.
//  4. Pause, resume and stop:
//     - Stimulus: in RUN at Q=4, Stop; then Start; then Stop twice.
//     - Response: Stop gives PAUSE, Q=4 held, J=K=0. Start resumes to 5.
//       Stop twice gives Q=0, IDLE, Busy=0.
//  5. Priority cases:
//     - Stimulus: Start=Stop=1 in IDLE.
//     - Response: stays IDLE, Q unchanged.
//     - Stimulus: LoadEn=1 with LoadVal=3 in RUN.
//     - Response: ignored, counting continues.
//  6. Async reset mid-run:
//     - Stimulus: assert Resetn between edges at Q=6.
//     - Response: Q=0, Busy=0, Tc=0 immediately; after release, stays IDLE until Start.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared encodings for the JK counter sequencer: FSM states, per-bit JK excitation
// codes and the controller's internal bank action.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Bit 1 is J, bit 0 is K.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_e;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CNT  = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_CLR  = 2'd3
    } act_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-high reset to 0.
module jk_cell (
    input  logic Clk,
    input  logic Resetn,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_q, q_d;

    always_comb begin
        q_d = q_q;
        unique case ({J, K})
            2'b00: q_d = q_q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Resetn) begin
        if (Resetn) q_q <= 1'b0;
        else        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_count_ctrl.sv
// Run/pause/stop sequencer driving a bank of JK cells as a mod-MODULUS up/down counter.
// J/K are combinational from state, Q and the control inputs; Busy and Tc are registered.
module jk_count_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Up,
    input  logic             LoadEn,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Busy,
    output logic             Tc
);

    localparam int             W1    = WIDTH + 1;
    localparam logic [WIDTH:0] MOD_W = W1'(MODULUS);
    localparam logic [WIDTH:0] LAST  = W1'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE   = W1'(1);

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 tc_q, tc_d;
    act_e                 act;
    logic [WIDTH:0]       q_ext, cnt_n;
    logic [WIDTH-1:0]     load_n;
    logic                 wrap;
    logic [WIDTH-1:0][1:0] ex;

    assign q_ext = {1'b0, Q};

    // One extra bit keeps Q+1 from overflowing when MODULUS == 2**WIDTH.
    always_comb begin
        wrap  = 1'b0;
        cnt_n = q_ext;
        if (Up) begin
            cnt_n = q_ext + ONE;
            if (cnt_n >= MOD_W) begin
                cnt_n = '0;
                wrap  = 1'b1;
            end
        end else if (q_ext == '0) begin
            cnt_n = LAST;
            wrap  = 1'b1;
        end else begin
            cnt_n = q_ext - ONE;
        end
        load_n = ({1'b0, LoadVal} >= MOD_W) ? LAST[WIDTH-1:0] : LoadVal;
    end

    // Stop outranks Start everywhere; Start outranks LoadEn.
    always_comb begin
        state_d = state_q;
        act     = ACT_HOLD;
        tc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!Stop) begin
                    if (Start)       state_d = ST_RUN;
                    else if (LoadEn) act     = ACT_LOAD;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_PAUSE;
                end else begin
                    act  = ACT_CNT;
                    tc_d = wrap;
                end
            end
            ST_PAUSE: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                    act     = ACT_CLR;
                end else if (Start) begin
                    state_d = ST_RUN;
                end else if (LoadEn) begin
                    act = ACT_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (Resetn) act = ACT_HOLD;
        busy_d = (state_d == ST_RUN);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            unique case (act)
                ACT_CNT:  ex[i] = (cnt_n[i] != Q[i]) ? JK_TOG : JK_HOLD;
                ACT_LOAD: ex[i] = load_n[i] ? JK_SET : JK_CLR;
                ACT_CLR:  ex[i] = JK_CLR;
                default:  ex[i] = JK_HOLD;
            endcase
            J[i] = ex[i][1];
            K[i] = ex[i][0];
        end
    end

    always_ff @(posedge Clk or posedge Resetn) begin
        if (Resetn) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
        end
    end

    assign Busy = busy_q;
    assign Tc   = tc_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .Clk    (Clk),
            .Resetn (Resetn),
            .J      (J[i]),
            .K      (K[i]),
            .Q      (Q[i])
        );
    end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Bench for jk_count_ctrl: integer-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_jk_count_ctrl;

    localparam int M = 10;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b1;
    logic       Start = 1'b0, Stop = 1'b0, Up = 1'b1, LoadEn = 1'b0;
    logic [3:0] LoadVal = '0;
    logic [3:0] Q, J, K;
    logic       Busy, Tc;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: 0 = idle, 1 = run, 2 = pause.
    int m_st = 0;
    int m_q = 0;
    bit m_tc = 1'b0;

    jk_count_ctrl #(.WIDTH(4), .MODULUS(M)) dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .Stop(Stop), .Up(Up),
        .LoadEn(LoadEn), .LoadVal(LoadVal), .Q(Q), .J(J), .K(K), .Busy(Busy), .Tc(Tc)
    );

    always #20 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // kind: 0 hold, 1 count, 2 load, 3 clear
    task automatic decide(input int st, input int q, output int kind, output int nq,
                          output int nst, output bit wrap);
        int lv;
        kind = 0; nq = q; nst = st; wrap = 1'b0;
        lv = (int'(LoadVal) >= M) ? M - 1 : int'(LoadVal);
        case (st)
            0: if (!Stop) begin
                   if (Start)       nst = 1;
                   else if (LoadEn) begin kind = 2; nq = lv; end
               end
            1: if (Stop) nst = 2;
               else begin
                   kind = 1;
                   if (Up) begin nq = (q + 1) % M;     wrap = (q == M - 1); end
                   else    begin nq = (q + M - 1) % M; wrap = (q == 0);     end
               end
            default: if (Stop) begin nst = 0; kind = 3; nq = 0; end
                     else if (Start) nst = 1;
                     else if (LoadEn) begin kind = 2; nq = lv; end
        endcase
    endtask

    always @(posedge Clk or posedge Resetn) begin : mdl
        int kind, nq, nst;
        bit wrap;
        if (Resetn) begin
            m_st <= 0; m_q <= 0; m_tc <= 1'b0;
        end else begin
            decide(m_st, m_q, kind, nq, nst, wrap);
            m_st <= nst;
            m_q  <= nq;
            m_tc <= (kind == 1) && wrap;
        end
    end

    always @(negedge Clk) begin : cmp
        int kind, nq, nst;
        bit wrap;
        logic [3:0] ej, ek, qv, nv;
        if (chk_en) begin
            decide(m_st, m_q, kind, nq, nst, wrap);
            qv = m_q[3:0];
            nv = nq[3:0];
            ej = '0; ek = '0;
            if (!Resetn) begin
                if (kind == 1) begin ej = qv ^ nv; ek = qv ^ nv; end
                else if (kind >= 2) begin ej = nv; ek = ~nv; end
            end
            chk("model_q", int'(Q), m_q);
            chk("model_busy", int'(Busy), (m_st == 1) ? 1 : 0);
            chk("model_tc", int'(Tc), int'(m_tc));
            chk("model_j", int'(J), int'(ej));
            chk("model_k", int'(K), int'(ek));
        end
    end

    task automatic drive(input logic s, input logic p, input logic u, input logic l,
                         input logic [3:0] v);
        Start = s; Stop = p; Up = u; LoadEn = l; LoadVal = v;
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        // Reset held, Start asserted: excitation must stay all-HOLD.
        Start = 1'b1;
        #30;
        chk("rst_q", int'(Q), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_tc", int'(Tc), 0);
        chk("rst_j", int'(J), 0);
        chk("rst_k", int'(K), 0);
        chk_en = 1'b1;
        drive(0, 0, 1, 0, 4'd0);
        tick();
        Resetn = 1'b0;

        // Count up with wrap
        drive(1, 0, 1, 0, 4'd0);
        tick();
        chk("start_busy", int'(Busy), 1);
        chk("start_q_held", int'(Q), 0);
        drive(0, 0, 1, 0, 4'd0);
        repeat (9) tick();
        chk("up_q9", int'(Q), 9);
        chk("up_tc_before_wrap", int'(Tc), 0);
        #1;
        chk("up_wrap_j", int'(J), 4'b1001);
        tick();
        chk("up_wrap_q", int'(Q), 0);
        chk("up_wrap_tc", int'(Tc), 1);
        tick();
        chk("up_tc_clear", int'(Tc), 0);
        chk("up_q1", int'(Q), 1);

        // Count down with wrap
        drive(0, 0, 0, 0, 4'd0);
        tick();
        chk("dn_q0", int'(Q), 0);
        tick();
        chk("dn_wrap_q", int'(Q), 9);
        chk("dn_wrap_tc", int'(Tc), 1);
        repeat (6) tick();
        chk("dn_q3", int'(Q), 3);
        #1;
        chk("dn_3to2_j", int'(J), 4'b0001);
        chk("dn_3to2_k", int'(K), 4'b0001);
        tick();
        chk("dn_q2", int'(Q), 2);

        // Pause, resume and stop
        drive(0, 0, 1, 0, 4'd0);
        repeat (2) tick();
        chk("pr_q4", int'(Q), 4);
        drive(0, 1, 1, 0, 4'd0);
        #1;
        chk("pause_j", int'(J), 0);
        chk("pause_k", int'(K), 0);
        tick();
        chk("pause_busy", int'(Busy), 0);
        chk("pause_q", int'(Q), 4);
        drive(0, 0, 1, 0, 4'd0);
        tick();
        chk("pause_hold_q", int'(Q), 4);
        drive(1, 0, 1, 0, 4'd0);
        tick();
        chk("resume_busy", int'(Busy), 1);
        chk("resume_q", int'(Q), 4);
        drive(0, 0, 1, 0, 4'd0);
        tick();
        chk("resume_q5", int'(Q), 5);
        drive(0, 1, 1, 0, 4'd0);
        tick();
        chk("stop1_q", int'(Q), 5);
        #1;
        chk("stop2_j", int'(J), 0);
        chk("stop2_k", int'(K), 4'hF);
        tick();
        chk("stop2_q", int'(Q), 0);
        chk("stop2_busy", int'(Busy), 0);
        chk("stop2_tc", int'(Tc), 0);

        // Load and clamp
        drive(0, 0, 1, 1, 4'd7);
        #1;
        chk("load7_j", int'(J), 4'b0111);
        chk("load7_k", int'(K), 4'b1000);
        tick();
        chk("load7_q", int'(Q), 7);
        drive(0, 0, 1, 1, 4'd12);
        tick();
        chk("load12_q", int'(Q), 9);
        chk("load_tc", int'(Tc), 0);
        drive(0, 0, 1, 0, 4'd0);
        tick();
        chk("idle_hold_q", int'(Q), 9);

        // Priority cases
        drive(1, 1, 1, 0, 4'd0);
        tick();
        chk("ss_busy", int'(Busy), 0);
        chk("ss_q", int'(Q), 9);
        drive(1, 0, 1, 0, 4'd0);
        tick();
        drive(0, 0, 1, 1, 4'd3);
        tick();
        chk("ld_in_run_q", int'(Q), 0);
        chk("ld_in_run_tc", int'(Tc), 1);
        tick();
        chk("ld_in_run_q1", int'(Q), 1);

        // Async reset mid-run
        drive(0, 0, 1, 0, 4'd0);
        repeat (5) tick();
        chk("pre_rst_q6", int'(Q), 6);
        #5 Resetn = 1'b1;
        #1;
        chk("arst_q", int'(Q), 0);
        chk("arst_busy", int'(Busy), 0);
        chk("arst_tc", int'(Tc), 0);
        tick();
        Resetn = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", int'(Busy), 0);
        chk("post_rst_q", int'(Q), 0);
        drive(1, 0, 1, 0, 4'd0);
        tick();
        chk("post_rst_start", int'(Busy), 1);
        drive(0, 0, 1, 0, 4'd0);
        tick();
        chk("post_rst_count", int'(Q), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
